// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer with start/stop button, preset load and alarm.
// One decrement every TICK_DIV clocks while running; all outputs are registered.
module countdown_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       CK,
  input  logic       nRES,
  input  logic       Z,
  input  logic       LD,
  input  logic [3:0] D_TENS,
  input  logic [3:0] D_ONES,
  output logic [3:0] Q_TENS,
  output logic [3:0] Q_ONES,
  output logic       RUN,
  output logic       DONE,
  output logic       ALM
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [7:0] presc_q, presc_d;
  logic       z_prev_q, z_prev_d;
  logic       run_q, run_d;
  logic       alm_q, alm_d;
  logic       done_q, done_d;

  logic       z_edge;
  logic       tick;
  logic       at_zero;
  logic       at_one;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // BCD decrement of a non-zero two-digit value: {tens, ones}.
  function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
    logic [7:0] r;
    if (o != 4'd0) r = {t, o - 4'd1};
    else           r = {t - 4'd1, 4'd9};
    return r;
  endfunction

  assign z_edge  = Z & ~z_prev_q;
  assign tick    = (presc_q == PRESC_LAST);
  assign at_zero = (tens_q == 4'd0) && (ones_q == 4'd0);
  assign at_one  = (tens_q == 4'd0) && (ones_q == 4'd1);

  always_comb begin
    state_d  = state_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    presc_d  = presc_q;
    z_prev_d = Z;
    done_d   = 1'b0;

    if (LD) begin
      // Load wins over any button edge or pending tick.
      tens_d  = clamp_bcd(D_TENS);
      ones_d  = clamp_bcd(D_ONES);
      state_d = ST_IDLE;
      presc_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (z_edge && !at_zero) begin
            state_d = ST_RUN;
            presc_d = 8'd0;
          end
        end
        ST_RUN: begin
          if (z_edge) begin
            // Pause; a tick on this same cycle is dropped.
            state_d = ST_IDLE;
            presc_d = 8'd0;
          end else if (tick) begin
            presc_d          = 8'd0;
            {tens_d, ones_d} = bcd_dec(tens_q, ones_q);
            if (at_one) begin
              state_d = ST_ALARM;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 8'd1;
          end
        end
        ST_ALARM: begin
          if (z_edge) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = 8'd0;
        end
      endcase
    end

    run_d = (state_d == ST_RUN);
    alm_d = (state_d == ST_ALARM);
  end

  always_ff @(posedge CK) begin
    if (!nRES) begin
      state_q  <= ST_IDLE;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      presc_q  <= 8'd0;
      z_prev_q <= 1'b0;
      run_q    <= 1'b0;
      alm_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      presc_q  <= presc_d;
      z_prev_q <= z_prev_d;
      run_q    <= run_d;
      alm_q    <= alm_d;
      done_q   <= done_d;
    end
  end

  assign Q_TENS = tens_q;
  assign Q_ONES = ones_q;
  assign RUN    = run_q;
  assign ALM    = alm_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scenario bench for countdown_timer: two instances (TICK_DIV=1 and 4) share stimulus;
// each scenario pushes the expected observation per cycle and pops it after the clock edge.
module tb_countdown_timer;

  typedef struct packed {
    logic       run;
    logic       alm;
    logic       done;
    logic [3:0] qt;
    logic [3:0] qo;
  } obs_t;

  typedef struct packed {
    logic       n;
    logic       l;
    logic       zz;
    logic [3:0] t;
    logic [3:0] o;
    obs_t       e;
  } row_t;

  logic       clk = 1'b0;
  logic       nres, z, ld;
  logic [3:0] dt, dn;

  logic [3:0] qt1, qo1, qt4, qo4;
  logic       run1, done1, alm1, run4, done4, alm4;
  obs_t       o1, o4;

  obs_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  countdown_timer #(.TICK_DIV(1)) dut1 (
    .CK(clk), .nRES(nres), .Z(z), .LD(ld), .D_TENS(dt), .D_ONES(dn),
    .Q_TENS(qt1), .Q_ONES(qo1), .RUN(run1), .DONE(done1), .ALM(alm1)
  );

  countdown_timer #(.TICK_DIV(4)) dut4 (
    .CK(clk), .nRES(nres), .Z(z), .LD(ld), .D_TENS(dt), .D_ONES(dn),
    .Q_TENS(qt4), .Q_ONES(qo4), .RUN(run4), .DONE(done4), .ALM(alm4)
  );

  assign o1 = {run1, alm1, done1, qt1, qo1};
  assign o4 = {run4, alm4, done4, qt4, qo4};

  // Row: reset_n, ld, z, d_tens, d_ones -> expected run, alm, done, q_tens, q_ones after the edge.
  function automatic row_t R(input int n, input int l, input int zz, input int t, input int o,
                             input int run, input int alm, input int done, input int et, input int eo);
    row_t r;
    r.n      = (n != 0);
    r.l      = (l != 0);
    r.zz     = (zz != 0);
    r.t      = 4'(t);
    r.o      = 4'(o);
    r.e.run  = (run != 0);
    r.e.alm  = (alm != 0);
    r.e.done = (done != 0);
    r.e.qt   = 4'(et);
    r.e.qo   = 4'(eo);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input row_t r);
    nres = r.n;
    ld   = r.l;
    z    = r.zz;
    dt   = r.t;
    dn   = r.o;
  endtask

  task automatic test_reset();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(R(0,1,0,9,9, 0,0,0,0,0));
    rows.push_back(R(0,1,1,5,5, 0,0,0,0,0));
    rows.push_back(R(1,0,0,0,0, 0,0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      step();
      want = exp_q.pop_front();
      got = o1;
      n_chk++;
      if (got !== want) $display("FAIL reset_d1 row %0d: got %h need %h", i, got, want);
      else n_pass++;
      got = o4;
      n_chk++;
      if (got !== want) $display("FAIL reset_d4 row %0d: got %h need %h", i, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_basic();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(R(1,1,0,0,3, 0,0,0,0,3));
    rows.push_back(R(1,0,1,0,0, 1,0,0,0,3));
    rows.push_back(R(1,0,0,0,0, 1,0,0,0,2));
    rows.push_back(R(1,0,0,0,0, 1,0,0,0,1));
    rows.push_back(R(1,0,0,0,0, 0,1,1,0,0));
    rows.push_back(R(1,0,0,0,0, 0,1,0,0,0));
    rows.push_back(R(1,0,0,0,0, 0,1,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      step();
      want = exp_q.pop_front();
      got = o1;
      n_chk++;
      if (got !== want) $display("FAIL basic row %0d: got %h need %h", i, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(R(1,1,0,1,0, 0,0,0,1,0));
    rows.push_back(R(1,0,1,0,0, 1,0,0,1,0));
    rows.push_back(R(1,0,0,0,0, 1,0,0,0,9));
    rows.push_back(R(1,0,0,0,0, 1,0,0,0,8));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      step();
      want = exp_q.pop_front();
      got = o1;
      n_chk++;
      if (got !== want) $display("FAIL wrap row %0d: got %h need %h", i, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_prescale();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(R(1,1,0,0,2, 0,0,0,0,2));
    rows.push_back(R(1,0,1,0,0, 1,0,0,0,2));
    rows.push_back(R(1,0,0,0,0, 1,0,0,0,2));
    rows.push_back(R(1,0,0,0,0, 1,0,0,0,2));
    rows.push_back(R(1,0,0,0,0, 1,0,0,0,2));
    rows.push_back(R(1,0,0,0,0, 1,0,0,0,1));
    rows.push_back(R(1,0,0,0,0, 1,0,0,0,1));
    rows.push_back(R(1,0,1,0,0, 0,0,0,0,1));
    rows.push_back(R(1,0,0,0,0, 0,0,0,0,1));
    rows.push_back(R(1,0,1,0,0, 1,0,0,0,1));
    rows.push_back(R(1,0,0,0,0, 1,0,0,0,1));
    rows.push_back(R(1,0,0,0,0, 1,0,0,0,1));
    rows.push_back(R(1,0,0,0,0, 1,0,0,0,1));
    rows.push_back(R(1,0,0,0,0, 0,1,1,0,0));
    rows.push_back(R(1,0,0,0,0, 0,1,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      step();
      want = exp_q.pop_front();
      got = o4;
      n_chk++;
      if (got !== want) $display("FAIL prescale row %0d: got %h need %h", i, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_z_edge();
    row_t rows[$];
    obs_t got, want;
    // Z held high for five clocks: one start only.
    rows.push_back(R(1,1,0,0,5, 0,0,0,0,5));
    rows.push_back(R(1,0,1,0,0, 1,0,0,0,5));
    rows.push_back(R(1,0,1,0,0, 1,0,0,0,5));
    rows.push_back(R(1,0,1,0,0, 1,0,0,0,5));
    rows.push_back(R(1,0,1,0,0, 1,0,0,0,5));
    rows.push_back(R(1,0,1,0,0, 1,0,0,0,4));
    rows.push_back(R(1,0,0,0,0, 1,0,0,0,4));
    // Start request with value 00 is ignored.
    rows.push_back(R(1,1,0,0,0, 0,0,0,0,0));
    rows.push_back(R(1,0,1,0,0, 0,0,0,0,0));
    rows.push_back(R(1,0,0,0,0, 0,0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      step();
      want = exp_q.pop_front();
      got = o4;
      n_chk++;
      if (got !== want) $display("FAIL z_edge row %0d: got %h need %h", i, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_pause_on_tick();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(R(1,1,0,0,5, 0,0,0,0,5));
    rows.push_back(R(1,0,1,0,0, 1,0,0,0,5));
    rows.push_back(R(1,0,0,0,0, 1,0,0,0,4));
    rows.push_back(R(1,0,1,0,0, 0,0,0,0,4));
    rows.push_back(R(1,0,0,0,0, 0,0,0,0,4));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      step();
      want = exp_q.pop_front();
      got = o1;
      n_chk++;
      if (got !== want) $display("FAIL pause_tick row %0d: got %h need %h", i, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_clamp_alarm();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(R(1,1,0,12,15, 0,0,0,9,9));
    rows.push_back(R(1,1,0,0,1,   0,0,0,0,1));
    rows.push_back(R(1,0,1,0,0,   1,0,0,0,1));
    rows.push_back(R(1,0,0,0,0,   0,1,1,0,0));
    rows.push_back(R(1,0,0,0,0,   0,1,0,0,0));
    rows.push_back(R(1,1,1,4,2,   0,0,0,4,2));
    rows.push_back(R(1,0,0,0,0,   0,0,0,4,2));
    // Plain Z edge leaves ALARM for IDLE.
    rows.push_back(R(1,1,0,0,1,   0,0,0,0,1));
    rows.push_back(R(1,0,1,0,0,   1,0,0,0,1));
    rows.push_back(R(1,0,0,0,0,   0,1,1,0,0));
    rows.push_back(R(1,0,1,0,0,   0,0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      step();
      want = exp_q.pop_front();
      got = o1;
      n_chk++;
      if (got !== want) $display("FAIL clamp_alarm row %0d: got %h need %h", i, got, want);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    obs_t got, want;
    rows.push_back(R(1,1,0,4,7, 0,0,0,4,7));
    rows.push_back(R(1,0,1,0,0, 1,0,0,4,7));
    rows.push_back(R(0,0,0,0,0, 0,0,0,0,0));
    rows.push_back(R(1,0,0,0,0, 0,0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      step();
      want = exp_q.pop_front();
      got = o4;
      n_chk++;
      if (got !== want) $display("FAIL reset_run row %0d: got %h need %h", i, got, want);
      else n_pass++;
    end
    // Reset on the very edge that would reach 00: no DONE, no ALARM.
    rows.delete();
    rows.push_back(R(1,1,0,0,1, 0,0,0,0,1));
    rows.push_back(R(1,0,1,0,0, 1,0,0,0,1));
    rows.push_back(R(0,0,0,0,0, 0,0,0,0,0));
    rows.push_back(R(1,0,0,0,0, 0,0,0,0,0));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      exp_q.push_back(rows[i].e);
      step();
      want = exp_q.pop_front();
      got = o1;
      n_chk++;
      if (got !== want) $display("FAIL reset_done row %0d: got %h need %h", i, got, want);
      else n_pass++;
    end
  endtask

  initial begin
    nres = 1'b0;
    ld   = 1'b0;
    z    = 1'b0;
    dt   = 4'd0;
    dn   = 4'd0;
    #2;
    test_reset();
    test_basic();
    test_wrap();
    test_prescale();
    test_z_edge();
    test_pause_on_tick();
    test_clamp_alarm();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
